// File: rtl/flash_pkg.sv
// Shared definitions for the I2C flash command sequencer.
// Holds the default widths, the sequencer state encoding and the
// positions of the bank/block fields inside the first address byte.
package flash_pkg;

    localparam int DATA_W  = 8;
    localparam int BANK_W  = 4;
    localparam int BLOCK_W = 4;
    localparam int ROW_W   = 8;

    // First address byte layout: bank in the upper nibble, block in the lower.
    localparam int BANK_LSB  = 4;
    localparam int BLOCK_LSB = 0;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR_HI    = 4'd1,
        ADDR_LO    = 4'd2,
        WAIT_DATA  = 4'd3,
        WR_SETUP   = 4'd4,
        WR_STROBE  = 4'd5,
        WR_HOLD    = 4'd6,
        RD_SETUP   = 4'd7,
        RD_STROBE  = 4'd8,
        RD_CAPTURE = 4'd9,
        RD_PRESENT = 4'd10
    } seq_state_e;

endpackage

// File: rtl/addr_pointer.sv
// Persistent bank/block/row address pointer.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   load_hi        - load bank/block from the first address byte
//   load_lo        - load row from the second address byte
//   inc            - advance row by one, wrapping; bank/block never carry
//   load_byte      - address byte being loaded
//   bank/block/row - current pointer value
module addr_pointer #(
    parameter int DATA_W  = flash_pkg::DATA_W,
    parameter int BANK_W  = flash_pkg::BANK_W,
    parameter int BLOCK_W = flash_pkg::BLOCK_W,
    parameter int ROW_W   = flash_pkg::ROW_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_hi,
    input  logic               load_lo,
    input  logic               inc,
    input  logic [DATA_W-1:0]  load_byte,
    output logic [BANK_W-1:0]  bank,
    output logic [BLOCK_W-1:0] block,
    output logic [ROW_W-1:0]   row
);
    import flash_pkg::*;

    logic [BANK_W-1:0]  bank_r;
    logic [BLOCK_W-1:0] block_r;
    logic [ROW_W-1:0]   row_r;

    // Pointer registers; row load takes priority over an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_r  <= {BANK_W{1'b0}};
            block_r <= {BLOCK_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
        end else begin
            if (load_hi) begin
                bank_r  <= load_byte[BANK_LSB +: BANK_W];
                block_r <= load_byte[BLOCK_LSB +: BLOCK_W];
            end
            if (load_lo) begin
                row_r <= load_byte[ROW_W-1:0];
            end else if (inc) begin
                row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bank  = bank_r;
    assign block = block_r;
    assign row   = row_r;

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Turns bytes from the I2C slave front end into address-load, write and
// read accesses on memoryBank's active-low strobe port.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   i2cStart, i2cStop, rwBit    - bus condition pulses and R/W bit
//   rxByte/rxValid/rxReady      - received byte handshake
//   txByte/txValid/txReady      - transmit byte handshake
//   memDataIn/memDataOut        - memory write/read data
//   readEnable/writeEnable      - active-low memory strobes
//   addrBank/addrBlock/addrRow  - memory address from the pointer
module flash_cmd_sequencer #(
    parameter int DATA_W   = flash_pkg::DATA_W,
    parameter int BANK_W   = flash_pkg::BANK_W,
    parameter int BLOCK_W  = flash_pkg::BLOCK_W,
    parameter int ROW_W    = flash_pkg::ROW_W,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i2cStart,
    input  logic               i2cStop,
    input  logic               rwBit,
    input  logic [DATA_W-1:0]  rxByte,
    input  logic               rxValid,
    output logic               rxReady,
    output logic [DATA_W-1:0]  txByte,
    output logic               txValid,
    input  logic               txReady,
    output logic [DATA_W-1:0]  memDataIn,
    input  logic [DATA_W-1:0]  memDataOut,
    output logic               readEnable,
    output logic               writeEnable,
    output logic [BANK_W-1:0]  addrBank,
    output logic [BLOCK_W-1:0] addrBlock,
    output logic [ROW_W-1:0]   addrRow
);
    import flash_pkg::*;

    seq_state_e        state_r, state_next_s;
    logic              pend_start_r, pend_stop_r, pend_rw_r;
    logic              pend_start_next_s, pend_stop_next_s, pend_rw_next_s;
    logic              ev_start_s, ev_stop_s, ev_rw_s;
    logic              load_hi_s, load_lo_s, inc_s, data_ld_s, rx_hs_s;
    logic              re_r, we_r, rx_ready_r, tx_valid_r;
    logic [DATA_W-1:0] tx_byte_r, mem_data_r;

    addr_pointer #(
        .DATA_W (DATA_W),
        .BANK_W (BANK_W),
        .BLOCK_W(BLOCK_W),
        .ROW_W  (ROW_W)
    ) u_addr_pointer (
        .clk      (clk),
        .reset    (reset),
        .load_hi  (load_hi_s),
        .load_lo  (load_lo_s),
        .inc      (inc_s),
        .load_byte(rxByte),
        .bank     (addrBank),
        .block    (addrBlock),
        .row      (addrRow)
    );

    assign rx_hs_s = rxValid && rx_ready_r;

    // Effective bus event: a live pulse overrides anything recorded during
    // an access, the latest event wins, and STOP beats a same-cycle START.
    always_comb begin
        ev_stop_s  = pend_stop_r;
        ev_start_s = pend_start_r;
        ev_rw_s    = pend_rw_r;
        if (i2cStop) begin
            ev_stop_s  = 1'b1;
            ev_start_s = 1'b0;
        end else if (i2cStart) begin
            ev_stop_s  = 1'b0;
            ev_start_s = 1'b1;
            ev_rw_s    = rwBit;
        end else begin
            ev_stop_s  = pend_stop_r;
            ev_start_s = pend_start_r;
        end
    end

    // Next-state logic; recorded events are only kept while an access runs.
    always_comb begin
        state_next_s      = state_r;
        pend_start_next_s = 1'b0;
        pend_stop_next_s  = 1'b0;
        pend_rw_next_s    = 1'b0;
        load_hi_s         = 1'b0;
        load_lo_s         = 1'b0;
        inc_s             = 1'b0;
        data_ld_s         = 1'b0;
        case (state_r)
            IDLE, ADDR_HI, ADDR_LO, WAIT_DATA: begin
                if (ev_stop_s) begin
                    state_next_s = IDLE;
                end else if (ev_start_s) begin
                    state_next_s = ev_rw_s ? RD_SETUP : ADDR_HI;
                end else if (rx_hs_s && (state_r == ADDR_HI)) begin
                    load_hi_s    = 1'b1;
                    state_next_s = ADDR_LO;
                end else if (rx_hs_s && (state_r == ADDR_LO)) begin
                    load_lo_s    = 1'b1;
                    state_next_s = WAIT_DATA;
                end else if (rx_hs_s && (state_r == WAIT_DATA)) begin
                    data_ld_s    = 1'b1;
                    state_next_s = WR_SETUP;
                end else begin
                    state_next_s = state_r;
                end
            end
            WR_SETUP, WR_STROBE, RD_SETUP, RD_STROBE: begin
                pend_start_next_s = ev_start_s;
                pend_stop_next_s  = ev_stop_s;
                pend_rw_next_s    = ev_rw_s;
                case (state_r)
                    WR_SETUP:  state_next_s = WR_STROBE;
                    WR_STROBE: state_next_s = WR_HOLD;
                    RD_SETUP:  state_next_s = RD_STROBE;
                    default:   state_next_s = RD_CAPTURE;
                endcase
            end
            WR_HOLD: begin
                // The write has landed, so the pointer advances even when
                // the access is being closed by a recorded bus event.
                inc_s = AUTO_INC;
                if (ev_stop_s) begin
                    state_next_s = IDLE;
                end else if (ev_start_s) begin
                    state_next_s = ev_rw_s ? RD_SETUP : ADDR_HI;
                end else begin
                    state_next_s = WAIT_DATA;
                end
            end
            RD_CAPTURE: begin
                // An interrupted read is never presented and never advances.
                if (ev_stop_s) begin
                    state_next_s = IDLE;
                end else if (ev_start_s) begin
                    state_next_s = ev_rw_s ? RD_SETUP : ADDR_HI;
                end else begin
                    state_next_s = RD_PRESENT;
                end
            end
            RD_PRESENT: begin
                if (ev_stop_s) begin
                    state_next_s = IDLE;
                end else if (ev_start_s) begin
                    state_next_s = ev_rw_s ? RD_SETUP : ADDR_HI;
                end else if (txReady) begin
                    inc_s        = AUTO_INC;
                    state_next_s = RD_SETUP;
                end else begin
                    state_next_s = RD_PRESENT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, recorded events and registered outputs. Strobes and handshake
    // flags are decoded from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pend_start_r <= 1'b0;
            pend_stop_r  <= 1'b0;
            pend_rw_r    <= 1'b0;
            re_r         <= 1'b1;
            we_r         <= 1'b1;
            rx_ready_r   <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_byte_r    <= {DATA_W{1'b0}};
            mem_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            pend_start_r <= pend_start_next_s;
            pend_stop_r  <= pend_stop_next_s;
            pend_rw_r    <= pend_rw_next_s;
            re_r         <= (state_next_s != RD_STROBE);
            we_r         <= (state_next_s != WR_STROBE);
            rx_ready_r   <= (state_next_s inside {ADDR_HI, ADDR_LO, WAIT_DATA});
            tx_valid_r   <= (state_next_s == RD_PRESENT);
            if (state_r == RD_CAPTURE) begin
                tx_byte_r <= memDataOut;
            end
            if (data_ld_s) begin
                mem_data_r <= rxByte;
            end
        end
    end

    assign readEnable  = re_r;
    assign writeEnable = we_r;
    assign rxReady     = rx_ready_r;
    assign txValid     = tx_valid_r;
    assign txByte      = tx_byte_r;
    assign memDataIn   = mem_data_r;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: a behavioural memory on the strobe port,
// a transaction-level reference model (pointer + byte map) and a strobe
// monitor. Randomized transactions follow the directed scenarios.
module tb_flash_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       i2cStart, i2cStop, rwBit;
    logic [7:0] rxByte;
    logic       rxValid, rxReady;
    logic [7:0] txByte;
    logic       txValid, txReady;
    logic [7:0] memDataIn, memDataOut;
    logic       readEnable, writeEnable;
    logic [3:0] addrBank, addrBlock;
    logic [7:0] addrRow;

    int n_vec = 0;
    int n_err = 0;

    // memory behind the strobe port
    logic [7:0]  env_mem [0:65535];
    // reference model
    logic [7:0]  model_mem [int];
    logic [7:0]  m_hi, m_row;
    logic [23:0] exp_wlog [$];
    logic [23:0] act_wlog [$];
    // monitor state
    logic        prev_we, prev_re, prev_reset;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;
    int          re_pulses = 0;

    flash_cmd_sequencer dut (
        .clk(clk), .reset(reset), .i2cStart(i2cStart), .i2cStop(i2cStop),
        .rwBit(rwBit), .rxByte(rxByte), .rxValid(rxValid), .rxReady(rxReady),
        .txByte(txByte), .txValid(txValid), .txReady(txReady),
        .memDataIn(memDataIn), .memDataOut(memDataOut),
        .readEnable(readEnable), .writeEnable(writeEnable),
        .addrBank(addrBank), .addrBlock(addrBlock), .addrRow(addrRow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [15:0] k);
        return k[7:0] ^ {k[11:8], k[15:12]} ^ 8'hC3;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] k);
        int key;
        key = int'(k);
        return model_mem.exists(key) ? model_mem[key] : init_val(k);
    endfunction

    // memory acts on the falling strobe edges
    always @(negedge writeEnable) env_mem[{addrBank, addrBlock, addrRow}] = memDataIn;
    always @(negedge readEnable)  memDataOut = env_mem[{addrBank, addrBlock, addrRow}];

    // strobe monitor: one-cycle pulses, stable address/data around them
    always @(negedge clk) begin
        if (!reset && !prev_reset) begin
            if (!writeEnable) begin
                act_wlog.push_back({addrBank, addrBlock, addrRow, memDataIn});
                check("we_single", prev_we, 1);
                check("strobe_excl", readEnable, 1);
                check("we_setup", {addrBank, addrBlock, addrRow, memDataIn}, {prev_addr, prev_data});
            end else if (!prev_we) begin
                check("we_hold", {addrBank, addrBlock, addrRow, memDataIn}, {prev_addr, prev_data});
            end
            if (!readEnable) begin
                re_pulses++;
                check("re_single", prev_re, 1);
                check("re_setup", {addrBank, addrBlock, addrRow}, prev_addr);
            end
        end
        prev_we    = writeEnable;
        prev_re    = readEnable;
        prev_reset = reset;
        prev_addr  = {addrBank, addrBlock, addrRow};
        prev_data  = memDataIn;
    end

    task automatic check_wlog();
        check("wlog_len", act_wlog.size(), exp_wlog.size());
        while (act_wlog.size() > 0 && exp_wlog.size() > 0)
            check("wlog_entry", act_wlog.pop_front(), exp_wlog.pop_front());
        act_wlog.delete();
        exp_wlog.delete();
    endtask

    task automatic pulse_start(input logic rw);
        i2cStart = 1'b1;
        rwBit    = rw;
        @(negedge clk);
        i2cStart = 1'b0;
    endtask

    task automatic pulse_stop();
        i2cStop = 1'b1;
        @(negedge clk);
        i2cStop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic took;
        took    = 1'b0;
        rxByte  = b;
        rxValid = 1'b1;
        for (int n = 0; n < 40 && !took; n++) begin
            took = rxReady;
            @(negedge clk);
        end
        rxValid = 1'b0;
        check("rx_accept", took, 1);
    endtask

    // START(w), two address bytes, n data bytes, STOP right after the last byte
    task automatic do_write(input logic [7:0] hi, input logic [7:0] lo, input int n, input logic [31:0] bytes);
        logic [7:0] d;
        pulse_start(1'b0);
        send_byte(hi);
        send_byte(lo);
        m_hi  = hi;
        m_row = lo;
        for (int i = 0; i < n; i++) begin
            d = bytes[8*i +: 8];
            send_byte(d);
            model_mem[int'({m_hi, m_row})] = d;
            exp_wlog.push_back({m_hi, m_row, d});
            m_row = m_row + 8'd1;
        end
        pulse_stop();
        repeat (6) @(negedge clk);
        check("wr_ptr_hi", {addrBank, addrBlock}, m_hi);
        check("wr_ptr_row", addrRow, m_row);
        check("wr_idle_rx", rxReady, 0);
        check_wlog();
    endtask

    // optional address phase, (repeated) START(r), n bytes each held `hold` cycles
    task automatic do_read(input bit set_addr, input logic [7:0] hi, input logic [7:0] lo, input int n, input int hold);
        int lat, re0;
        logic [7:0] exp;
        if (set_addr) begin
            pulse_start(1'b0);
            send_byte(hi);
            send_byte(lo);
            m_hi  = hi;
            m_row = lo;
        end
        pulse_start(1'b1);
        for (int i = 0; i < n; i++) begin
            lat = 0;
            while (!txValid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("rd_latency", lat, 3);
            exp = model_rd({m_hi, m_row});
            check("rd_data", txByte, exp);
            re0 = re_pulses;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rd_hold_valid", txValid, 1);
                check("rd_hold_data", txByte, exp);
            end
            check("rd_no_refetch", re_pulses - re0, 0);
            check("rd_row", addrRow, m_row);
            txReady = 1'b1;
            @(negedge clk);
            txReady = 1'b0;
            m_row = m_row + 8'd1;
        end
        pulse_stop();
        repeat (6) @(negedge clk);
        check("rd_end_row", addrRow, m_row);
        check("rd_end_hi", {addrBank, addrBlock}, m_hi);
        check("rd_end_valid", txValid, 0);
        check_wlog();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] hi, lo;
        int n;
        for (int i = 0; i < 65536; i++) env_mem[i] = init_val(16'(i));
        memDataOut = 8'h00;
        reset = 1'b1; i2cStart = 1'b0; i2cStop = 1'b0; rwBit = 1'b0;
        rxByte = 8'h00; rxValid = 1'b0; txReady = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", writeEnable, 1);
        check("rst_re", readEnable, 1);
        check("rst_addr", {addrBank, addrBlock, addrRow}, 0);
        check("rst_mdata", memDataIn, 0);
        check("rst_tx", {txValid, txByte}, 0);
        check("rst_rxready", rxReady, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        m_hi = 8'h00; m_row = 8'h00;

        // reset in the middle of a write strobe
        pulse_start(1'b0);
        send_byte(8'h77);
        send_byte(8'h40);
        send_byte(8'h99);
        model_mem[int'(16'h7740)] = 8'h99;
        exp_wlog.push_back({16'h7740, 8'h99});
        n = 0;
        while (writeEnable && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_we_low", writeEnable, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_we", writeEnable, 1);
        check("rst_mid_addr", {addrBank, addrBlock, addrRow}, 0);
        check("rst_mid_tx", txValid, 0);
        check("rst_mid_rx", rxReady, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        m_hi = 8'h00; m_row = 8'h00;
        check_wlog();
        // current-address read from the cleared pointer
        do_read(1'b0, 8'h00, 8'h00, 1, 0);

        // directed sequential write then random read of the same bytes
        do_write(8'h3A, 8'h10, 2, 32'h0000AA55);
        check("dir_row", addrRow, 8'h12);
        do_read(1'b1, 8'h3A, 8'h10, 2, 0);
        check("dir_rd_row", addrRow, 8'h12);

        // row wrap inside one bank/block
        do_write(8'h5C, 8'hFF, 2, 32'h00002211);
        do_read(1'b1, 8'h5C, 8'hFF, 2, 1);

        // master stalls on a presented byte
        do_read(1'b1, 8'h3A, 8'h10, 1, 10);

        // STOP during WR_SETUP, then read the byte back
        do_write(8'h12, 8'h34, 1, 32'h000000E7);
        do_read(1'b1, 8'h12, 8'h34, 1, 0);

        // randomized transactions
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: hi = 8'h3A;
                1: hi = 8'h5C;
                default: hi = 8'($urandom_range(0, 255));
            endcase
            lo = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: do_write(hi, lo, int'($urandom_range(1, 4)), $urandom);
                1: do_read(1'b1, hi, lo, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
                default: do_read(1'b0, hi, lo, int'($urandom_range(1, 2)), int'($urandom_range(0, 2)));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
